// File: rtl/wr_en_decoder_pipe.sv
//------------------------------------------------------------------------------
// Module      : wr_en_decoder_pipe
// Description : Two-port pipelined register write-enable decoder. Each port
//               is decoded to a one-hot enable vector and registered for one
//               cycle. Writes to the hardwired zero register are suppressed.
//               On a same-address collision port A wins. Stall holds all
//               outputs, and flush clears them. Zero-register hits, illegal
//               addresses and collisions are reported as one-cycle flags.
// Options     : WRDEC_COLLISION_CNT_EN - when defined, builds a saturating
//               collision counter. When undefined, collision_cnt is tied to 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wr_en_decoder_pipe #(
    parameter int ADDR_W       = 5,
    parameter int NUM_REGS     = 32,
    parameter int HAS_ZERO_REG = 1,
    parameter int ZERO_REG     = 31,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                a_valid,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic                b_valid,
    input  logic [ADDR_W-1:0]   b_addr,
    output logic [NUM_REGS-1:0] a_dec,
    output logic [NUM_REGS-1:0] b_dec,
    output logic                zero_hit,
    output logic                addr_err,
    output logic                collision,
    output logic [CNT_W-1:0]    collision_cnt
);

    // One extra bit lets NUM_REGS == 2**ADDR_W compare correctly.
    localparam logic [ADDR_W:0]   c_NUM_REGS = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] c_ZERO_REG = ADDR_W'(ZERO_REG);

    logic                w_a_legal;
    logic                w_b_legal;
    logic                w_a_zero;
    logic                w_b_zero;
    logic                w_a_en;
    logic                w_b_en;
    logic                w_coll;
    logic                w_load;
    logic [NUM_REGS-1:0] w_a_onehot;
    logic [NUM_REGS-1:0] w_b_onehot;

    logic [NUM_REGS-1:0] r_a_dec;
    logic [NUM_REGS-1:0] r_b_dec;
    logic                r_zero_hit;
    logic                r_addr_err;
    logic                r_collision;

    // Raw address-to-one-hot decode for both ports.
    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_onehot
            assign w_a_onehot[i] = (a_addr == ADDR_W'(i));
            assign w_b_onehot[i] = (b_addr == ADDR_W'(i));
        end
    endgenerate

    // Classify each request: out of range, zero register, or a real write.
    always_comb begin
        w_a_legal = ({1'b0, a_addr} < c_NUM_REGS);
        w_b_legal = ({1'b0, b_addr} < c_NUM_REGS);
        w_a_zero  = (HAS_ZERO_REG != 0) && (a_addr == c_ZERO_REG);
        w_b_zero  = (HAS_ZERO_REG != 0) && (b_addr == c_ZERO_REG);
        w_a_en    = a_valid && w_a_legal && !w_a_zero;
        w_b_en    = b_valid && w_b_legal && !w_b_zero;
        // Both sides are real writes, so an equal address is a true collision.
        w_coll    = w_a_en && w_b_en && (a_addr == b_addr);
        // New inputs are taken only when the stage is neither flushed nor stalled.
        w_load    = !flush && !stall;
    end

    // Pipeline register: reset, then flush, then stall, then a normal load.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            r_a_dec     <= '0;
            r_b_dec     <= '0;
            r_zero_hit  <= 1'b0;
            r_addr_err  <= 1'b0;
            r_collision <= 1'b0;
        end else if (!stall) begin
            r_a_dec     <= w_a_en ? w_a_onehot : '0;
            r_b_dec     <= (w_b_en && !w_coll) ? w_b_onehot : '0;
            r_zero_hit  <= (a_valid && w_a_legal && w_a_zero) ||
                           (b_valid && w_b_legal && w_b_zero);
            r_addr_err  <= (a_valid && !w_a_legal) || (b_valid && !w_b_legal);
            r_collision <= w_coll;
        end
    end

`ifdef WRDEC_COLLISION_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Saturating collision counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_load && w_coll && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign collision_cnt = r_cnt;
`else
    logic w_unused_load;
    assign w_unused_load = w_load;
    assign collision_cnt = '0;
`endif

    assign a_dec     = r_a_dec;
    assign b_dec     = r_b_dec;
    assign zero_hit  = r_zero_hit;
    assign addr_err  = r_addr_err;
    assign collision = r_collision;

endmodule

`default_nettype wire

// File: tb/tb_wr_en_decoder_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_wr_en_decoder_pipe
// Description : Directed self-checking bench for wr_en_decoder_pipe. It runs
//               a default 32-register instance and a 24-register instance
//               from the same stimulus.
// Options     : WRDEC_COLLISION_CNT_EN - selects the expected counter values.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wr_en_decoder_pipe;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic        b_valid;
    logic [4:0]  b_addr;

    logic [31:0] a_dec;
    logic [31:0] b_dec;
    logic        zero_hit;
    logic        addr_err;
    logic        collision;
    logic [7:0]  collision_cnt;

    logic [23:0] a_dec24;
    logic [23:0] b_dec24;
    logic        zero_hit24;
    logic        addr_err24;
    logic        collision24;
    logic [7:0]  collision_cnt24;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    wr_en_decoder_pipe dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .a_valid(a_valid), .a_addr(a_addr), .b_valid(b_valid), .b_addr(b_addr),
        .a_dec(a_dec), .b_dec(b_dec), .zero_hit(zero_hit), .addr_err(addr_err),
        .collision(collision), .collision_cnt(collision_cnt)
    );

    wr_en_decoder_pipe #(.NUM_REGS(24)) dut24 (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .a_valid(a_valid), .a_addr(a_addr), .b_valid(b_valid), .b_addr(b_addr),
        .a_dec(a_dec24), .b_dec(b_dec24), .zero_hit(zero_hit24), .addr_err(addr_err24),
        .collision(collision24), .collision_cnt(collision_cnt24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model of the counter after an edge that loads a collision.
    task automatic count_collision();
`ifdef WRDEC_COLLISION_CNT_EN
        if (exp_cnt < 255) exp_cnt++;
`endif
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        a_valid = 1'b0; a_addr = 5'd0; b_valid = 1'b0; b_addr = 5'd0;
        step();
        step();
        check("rst_a_dec", a_dec, 0);
        check("rst_b_dec", b_dec, 0);
        check("rst_flags", {zero_hit, addr_err, collision}, 0);
        check("rst_cnt", collision_cnt, 0);

        // Two independent writes.
        reset_n = 1'b1;
        a_valid = 1'b1; a_addr = 5'd5; b_valid = 1'b1; b_addr = 5'd9;
        step();
        check("basic_a_dec", a_dec, 64'h20);
        check("basic_b_dec", b_dec, 64'h200);
        check("basic_flags", {zero_hit, addr_err, collision}, 0);

        // Write to the zero register; on the 24-register instance it is out of range.
        a_addr = 5'd31; b_valid = 1'b0;
        step();
        check("zero_a_dec", a_dec, 0);
        check("zero_hit", zero_hit, 1);
        check("zero_addr_err", addr_err, 0);
        check("zero24_addr_err", addr_err24, 1);
        check("zero24_zero_hit", zero_hit24, 0);
        a_valid = 1'b0;
        step();
        check("zero_pulse_end", zero_hit, 0);

        // Port B is a real write while port A hits the zero register.
        a_valid = 1'b1; a_addr = 5'd31; b_valid = 1'b1; b_addr = 5'd4;
        step();
        check("mix_a_dec", a_dec, 0);
        check("mix_b_dec", b_dec, 64'h10);
        check("mix_zero_hit", zero_hit, 1);

        // Repeated collisions drive the counter into saturation.
        a_addr = 5'd12; b_addr = 5'd12;
        for (int i = 0; i < 300; i++) begin
            step();
            count_collision();
            check("coll_a_dec", a_dec, 64'h1000);
            check("coll_b_dec", b_dec, 0);
            check("coll_flag", collision, 1);
            check("coll_cnt", collision_cnt, 64'(exp_cnt));
        end

        // Stall holds the loaded value and ignores the new address.
        b_valid = 1'b0; a_addr = 5'd3;
        step();
        check("stall_load", a_dec, 64'h8);
        check("stall_coll_clr", collision, 0);
        stall = 1'b1; a_addr = 5'd7; b_valid = 1'b1; b_addr = 5'd7;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_hold", a_dec, 64'h8);
            check("stall_cnt", collision_cnt, 64'(exp_cnt));
        end
        stall = 1'b0; b_valid = 1'b0;
        step();
        check("stall_release", a_dec, 64'h80);

        // Flush beats stall; the counter keeps its value.
        a_addr = 5'd12; b_valid = 1'b1; b_addr = 5'd12;
        step();
        count_collision();
        check("pre_flush_coll", collision, 1);
        flush = 1'b1; stall = 1'b1;
        step();
        check("flush_a_dec", a_dec, 0);
        check("flush_b_dec", b_dec, 0);
        check("flush_flags", {zero_hit, addr_err, collision}, 0);
        check("flush_cnt", collision_cnt, 64'(exp_cnt));

        // Reset during flush clears the counter.
        stall = 1'b0; reset_n = 1'b0;
        step();
        exp_cnt = 0;
        check("rst_flush_cnt", collision_cnt, 0);
        check("rst_flush_a_dec", a_dec, 0);

        // Out-of-range address on the 24-register instance.
        reset_n = 1'b1; flush = 1'b0;
        a_valid = 1'b1; a_addr = 5'd26; b_valid = 1'b0;
        step();
        check("ill24_a_dec", a_dec24, 0);
        check("ill24_addr_err", addr_err24, 1);
        check("ill24_coll", collision24, 0);
        check("ill32_a_dec", a_dec, 64'h400_0000);
        check("ill32_addr_err", addr_err, 0);

        // Equal illegal addresses on both ports are not a collision.
        b_valid = 1'b1; b_addr = 5'd26;
        step();
        count_collision();
        check("ill24_both_coll", collision24, 0);
        check("ill24_both_b_dec", b_dec24, 0);
        check("ill32_both_coll", collision, 1);
        check("ill32_both_cnt", collision_cnt, 64'(exp_cnt));

        // Top legal register on the 24-register instance.
        a_addr = 5'd23; b_valid = 1'b1; b_addr = 5'd0;
        step();
        check("top24_a_dec", a_dec24, 64'h80_0000);
        check("top24_b_dec", b_dec24, 64'h1);
        check("top24_addr_err", addr_err24, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
